// File: rtl/riscv_test_monitor.sv
// Pass/fail/timeout monitor for RISC-V compliance tests: samples gp at PASS_PC once armed by start.
// Optional build macro MONITOR_TOHOST_EN adds tohost store detection as a result source.
module riscv_test_monitor #(
  parameter int              XLEN            = 32,
  parameter logic [XLEN-1:0] PASS_PC         = 32'h44,
  parameter logic [XLEN-1:0] RESULT_REG_PASS = 32'd1,
  parameter int              TIMEOUT         = 5000,
  parameter int              CNT_W           = 32,
  parameter logic [XLEN-1:0] TOHOST_ADDR     = 32'h1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  result_reg,
  input  logic             st_valid,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  output logic             running,
  output logic             done,
  output logic             passed,
  output logic             failed,
  output logic             timed_out,
  output logic [XLEN-1:0]  fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RUN  = 3'd1,
    PASS = 3'd2,
    FAIL = 3'd3,
    TMO  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_nx_s;
  logic [CNT_W-1:0]  count_nx_s;
  logic [XLEN-1:0]   code_nx_s;
  logic              evt_s;
  logic              evt_pass_s;
  logic [XLEN-1:0]   evt_code_s;

`ifdef MONITOR_TOHOST_EN
  // Result event detection; a tohost store outranks the PC match.
  always_comb begin
    evt_s      = 1'b0;
    evt_pass_s = 1'b0;
    evt_code_s = {XLEN{1'b0}};
    if (st_valid && (st_addr == TOHOST_ADDR) && st_data[0]) begin
      evt_s      = 1'b1;
      evt_pass_s = (st_data == {{(XLEN-1){1'b0}}, 1'b1});
      evt_code_s = {1'b0, st_data[XLEN-1:1]};
    end else if (pc == PASS_PC) begin
      evt_s      = 1'b1;
      evt_pass_s = (result_reg == RESULT_REG_PASS);
      evt_code_s = {1'b0, result_reg[XLEN-1:1]};
    end else begin
      evt_s      = 1'b0;
    end
  end
`else
  // Store bus is not monitored in this build; fold it into a sink so nothing is built from it.
  logic unused_s;
  assign unused_s = ^{st_valid, st_addr, st_data, TOHOST_ADDR};

  // Result event detection from the PC match only.
  always_comb begin
    evt_s      = 1'b0;
    evt_pass_s = 1'b0;
    evt_code_s = {XLEN{1'b0}};
    if (pc == PASS_PC) begin
      evt_s      = 1'b1;
      evt_pass_s = (result_reg == RESULT_REG_PASS);
      evt_code_s = {1'b0, result_reg[XLEN-1:1]};
    end else begin
      evt_s      = 1'b0;
    end
  end
`endif

  // Next-state logic: start beats a result event, a result event beats the timeout.
  always_comb begin
    state_nx_s = state_r;
    count_nx_s = cycle_count;
    code_nx_s  = fail_code;
    case (state_r)
      RUN: begin
        if (start) begin
          count_nx_s = {CNT_W{1'b0}};
          code_nx_s  = {XLEN{1'b0}};
        end else if (evt_s) begin
          state_nx_s = evt_pass_s ? PASS : FAIL;
          code_nx_s  = evt_pass_s ? {XLEN{1'b0}} : evt_code_s;
        end else if (cycle_count == TMO_LAST) begin
          state_nx_s = TMO;
        end else if (cycle_count != CNT_MAX) begin
          count_nx_s = cycle_count + CNT_ONE;
        end else begin
          count_nx_s = cycle_count;
        end
      end
      IDLE, PASS, FAIL, TMO: begin
        if (start) begin
          state_nx_s = RUN;
          count_nx_s = {CNT_W{1'b0}};
          code_nx_s  = {XLEN{1'b0}};
        end else begin
          state_nx_s = state_r;
        end
      end
      default: begin
        state_nx_s = IDLE;
        count_nx_s = {CNT_W{1'b0}};
        code_nx_s  = {XLEN{1'b0}};
      end
    endcase
  end

  // State register with flags decoded from the next state so every output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cycle_count <= {CNT_W{1'b0}};
      fail_code   <= {XLEN{1'b0}};
      running     <= 1'b0;
      done        <= 1'b0;
      passed      <= 1'b0;
      failed      <= 1'b0;
      timed_out   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cycle_count <= count_nx_s;
      fail_code   <= code_nx_s;
      running     <= (state_nx_s == RUN);
      done        <= (state_nx_s == PASS) || (state_nx_s == FAIL) || (state_nx_s == TMO);
      passed      <= (state_nx_s == PASS);
      failed      <= (state_nx_s == FAIL);
      timed_out   <= (state_nx_s == TMO);
    end
  end

endmodule

// File: tb/tb_riscv_test_monitor.sv
// Scoreboard bench for riscv_test_monitor: a vector-walking reference model predicts each run's outcome.
module tb_riscv_test_monitor;

  localparam int TMO_P = 20;
  localparam int NV    = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] result_reg = 32'h0;
  logic        st_valid = 1'b0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic        running, done, passed, failed, timed_out;
  logic [31:0] fail_code;
  logic [31:0] cycle_count;

  riscv_test_monitor #(.TIMEOUT(TMO_P)) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc), .result_reg(result_reg),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data),
    .running(running), .done(done), .passed(passed), .failed(failed),
    .timed_out(timed_out), .fail_code(fail_code), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 1 pass, 2 fail, 3 timeout
    logic [31:0] code;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic        v_start [NV];
  logic [31:0] v_pc    [NV];
  logic [31:0] v_rr    [NV];
  logic        v_stv   [NV];
  logic [31:0] v_sta   [NV];
  logic [31:0] v_std   [NV];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] v;
    v = $urandom;
    if (v == 32'h44) v = 32'h48;
    return v;
  endfunction

  // Outcome rules: restart resets the cycle index, tohost beats the PC, results beat the timeout.
  function automatic void model(output exp_t e, output int jend);
    int k;
    k = 0;
    e.kind = 0; e.code = 0; e.cnt = 0; jend = NV - 1;
    for (int j = 0; j < NV; j++) begin
      if (v_start[j]) begin
        k = 0;
        continue;
      end
`ifdef MONITOR_TOHOST_EN
      if (v_stv[j] && v_sta[j] == 32'h1000 && v_std[j] % 2 == 1) begin
        e.kind = (v_std[j] == 1) ? 1 : 2;
        e.code = (v_std[j] == 1) ? 32'd0 : v_std[j] / 2;
        e.cnt = k; jend = j; return;
      end
`endif
      if (v_pc[j] == 32'h44) begin
        e.kind = (v_rr[j] == 1) ? 1 : 2;
        e.code = (v_rr[j] == 1) ? 32'd0 : v_rr[j] / 2;
        e.cnt = k; jend = j; return;
      end
      if (k == TMO_P - 1) begin
        e.kind = 3; e.code = 0; e.cnt = k; jend = j; return;
      end
      k++;
    end
  endfunction

  task automatic fill_quiet();
    for (int j = 0; j < NV; j++) begin
      v_start[j] = 1'b0;
      v_pc[j]    = rnd_pc();
      v_rr[j]    = $urandom;
      v_stv[j]   = ($urandom_range(0, 3) == 0);
      v_sta[j]   = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h2000;
      v_std[j]   = {$urandom, 1'b0} & 32'hFFFF_FFFE;
    end
  endtask

  task automatic fill_random();
    fill_quiet();
    for (int j = 0; j < NV; j++) begin
      v_start[j] = (j < 10) && ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 14) == 0) v_pc[j] = 32'h44;
      if ($urandom_range(0, 1) == 0) v_rr[j] = 32'd1;
      if ($urandom_range(0, 7) == 0) v_std[j] = ($urandom_range(0, 1) == 0) ? 32'd1 : ($urandom | 32'd1);
    end
  endtask

  task automatic junk_cycle();
    pc = ($urandom_range(0, 2) == 0) ? 32'h44 : rnd_pc();
    result_reg = ($urandom_range(0, 1) == 0) ? 32'd1 : $urandom;
    st_valid = $urandom_range(0, 1);
    st_addr = 32'h1000;
    st_data = $urandom;
    @(negedge clk);
  endtask

  task automatic run_test();
    exp_t e;
    int   jend;
    model(e, jend);
    sb.push_back(e);
    start = 1'b1; pc = rnd_pc(); st_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start_running", running, 1);
    chk("start_done", done, 0);
    chk("start_count", cycle_count, 0);
    chk("start_code", fail_code, 0);
    for (int j = 0; j <= jend; j++) begin
      start = v_start[j]; pc = v_pc[j]; result_reg = v_rr[j];
      st_valid = v_stv[j]; st_addr = v_sta[j]; st_data = v_std[j];
      @(negedge clk);
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) junk_cycle();
    if (sb.size() != 0) begin
      chk("no_result", sb.size(), 0);
      sb.delete();
    end
    chk("sticky_pass", passed, e.kind == 1);
    chk("sticky_fail", failed, e.kind == 2);
    chk("sticky_tmo", timed_out, e.kind == 3);
    chk("sticky_code", fail_code, e.code);
    chk("sticky_count", cycle_count, e.cnt);
  endtask

  logic done_q = 1'b0;

  // Monitor: on every rising done, pop the oldest prediction and compare.
  always @(negedge clk) begin
    if (done && !done_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", done, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_pass", passed, e.kind == 1);
        chk("res_fail", failed, e.kind == 2);
        chk("res_tmo", timed_out, e.kind == 3);
        chk("res_code", fail_code, e.code);
        chk("res_count", cycle_count, e.cnt);
        chk("res_running", running, 0);
      end
    end
    done_q <= done;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_running", running, 0);
    chk("rst_done", done, 0);
    chk("rst_count", cycle_count, 0);
    rst = 1'b0;
    repeat (2) junk_cycle();
    chk("idle_ignores_running", running, 0);
    chk("idle_ignores_done", done, 0);

    // Abort a run with an asynchronous reset at cycle 5.
    start = 1'b1; pc = rnd_pc(); @(negedge clk); start = 1'b0;
    repeat (5) begin pc = rnd_pc(); @(negedge clk); end
    chk("pre_abort_count", cycle_count, 5);
    #2 rst = 1'b1;
    #1;
    chk("abort_running", running, 0);
    chk("abort_flags", {done, passed, failed, timed_out}, 0);
    chk("abort_count", cycle_count, 0);
    chk("abort_code", fail_code, 0);
    @(negedge clk); rst = 1'b0;
    repeat (3) junk_cycle();
    chk("post_abort_idle", {running, done}, 0);

    // Pass at cycle 10.
    fill_quiet(); v_pc[10] = 32'h44; v_rr[10] = 32'd1; run_test();
    // Fail with gp=7.
    fill_quiet(); v_pc[0] = 32'h44; v_rr[0] = 32'd7; run_test();
    // Plain timeout.
    fill_quiet(); run_test();
    // Pass in the timeout cycle.
    fill_quiet(); v_pc[TMO_P-1] = 32'h44; v_rr[TMO_P-1] = 32'd1; run_test();
    // Restart coincident with a PASS-PC match, then a later pass.
    fill_quiet(); v_start[3] = 1'b1; v_pc[3] = 32'h44; v_rr[3] = 32'd1;
    v_pc[6] = 32'h44; v_rr[6] = 32'd1; run_test();
`ifdef MONITOR_TOHOST_EN
    fill_quiet(); v_pc[2] = 32'h44; v_rr[2] = 32'd1;
    v_stv[2] = 1'b1; v_sta[2] = 32'h1000; v_std[2] = 32'h0B; run_test();
`endif
    for (int t = 0; t < 30; t++) begin
      fill_random();
      run_test();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
